// File: rtl/bin_to_bcd_seq_if.sv
// Start/done handshake and result bus between the binary source, the
// bin_to_bcd_seq converter and the seven-segment display driver.
interface bin_to_bcd_seq_if #(
    parameter int BIN_WIDTH = 14
);
    logic [BIN_WIDTH-1:0] bin_in;
    logic                 start;
    logic                 busy;
    logic                 done;
    logic [15:0]          bcd_register;
    logic                 ovf;

    modport master (
        output bin_in,
        output start,
        input  busy,
        input  done,
        input  bcd_register,
        input  ovf
    );

    modport slave (
        input  bin_in,
        input  start,
        output busy,
        output done,
        output bcd_register,
        output ovf
    );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Iterative double-dabble binary-to-4-digit-BCD converter with start/done handshake.
// Optional macro BCD_SAT_EN clamps overflowing results (>9999) to 16'h9999.
module bin_to_bcd_seq #(
    parameter int BIN_WIDTH = 14
) (
    input  logic            clk,
    input  logic            rst,
    bin_to_bcd_seq_if.slave bus
);

    localparam int CNT_W = $clog2(BIN_WIDTH + 1);

    generate
        if (BIN_WIDTH < 4 || BIN_WIDTH > 14) begin : g_bad_width
            $error("bin_to_bcd_seq: BIN_WIDTH must be in 4..14");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t               state;
    logic [19:0]          scratch;
    logic [BIN_WIDTH-1:0] shreg;
    logic [CNT_W-1:0]     cnt;
    logic                 ovf_pending;

    logic [19:0]          scratch_adj;
    logic [19:0]          scratch_next;
    logic                 unused_carry;

    // Add-3 correction for one BCD digit before it is doubled by the shift.
    function automatic logic [3:0] add3(input logic [3:0] digit);
        return (digit >= 4'd5) ? digit + 4'd3 : digit;
    endfunction

`ifdef BCD_SAT_EN
    function automatic logic [15:0] saturate(input logic [15:0] value, input logic over);
        return over ? 16'h9999 : value;
    endfunction
`endif

    always_comb begin
        scratch_adj = '0;
        for (int d = 0; d < 5; d++) begin
            scratch_adj[d*4 +: 4] = add3(scratch[d*4 +: 4]);
        end
        scratch_next = {scratch_adj[18:0], shreg[BIN_WIDTH-1]};
    end

    // Top bit of the corrected scratch is shifted out and only matters as overflow.
    assign unused_carry = scratch_adj[19];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            scratch          <= '0;
            shreg            <= '0;
            cnt              <= '0;
            ovf_pending      <= 1'b0;
            bus.busy         <= 1'b0;
            bus.done         <= 1'b0;
            bus.bcd_register <= 16'h0000;
            bus.ovf          <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        shreg       <= bus.bin_in;
                        scratch     <= '0;
                        cnt         <= CNT_W'(BIN_WIDTH);
                        ovf_pending <= (32'(bus.bin_in) > 32'd9999);
                        bus.busy    <= 1'b1;
                        state       <= SHIFT;
                    end
                end
                SHIFT: begin
                    scratch <= scratch_next;
                    shreg   <= {shreg[BIN_WIDTH-2:0], 1'b0};
                    cnt     <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= FINISH;
                    end
                end
                FINISH: begin
`ifdef BCD_SAT_EN
                    bus.bcd_register <= saturate(scratch[15:0], ovf_pending);
`else
                    bus.bcd_register <= scratch[15:0];
`endif
                    bus.ovf  <= ovf_pending;
                    bus.done <= 1'b1;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed, table-driven bench for bin_to_bcd_seq (either BCD_SAT_EN build).
module tb_bin_to_bcd_seq;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    bin_to_bcd_seq_if #(.BIN_WIDTH(14)) bus ();

    bin_to_bcd_seq #(.BIN_WIDTH(14)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [13:0] bin;
        logic [15:0] bcd;
        logic        ovf;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Called right after a falling edge; start is sampled on the next rising edge (edge 0).
    task automatic do_conv(input logic [13:0] v, output int lat, output logic [15:0] r,
                           output logic o, output logic busy_ok);
        bus.bin_in = v;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start  = 1'b0;
        lat        = -1;
        busy_ok    = bus.busy;
        r          = 16'hxxxx;
        o          = 1'bx;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (bus.done) begin
                lat = c;
                r   = bus.bcd_register;
                o   = bus.ovf;
                break;
            end
            if (!bus.busy) busy_ok = 1'b0;
        end
    endtask

    initial begin
        int          lat;
        logic [15:0] r;
        logic        o;
        logic        bok;
        int          ndone;
        int          first;
        logic [15:0] got;

        n_tests = 0;
        n_fail  = 0;

        vecs[0]  = '{14'd0,     16'h0000, 1'b0};
        vecs[1]  = '{14'd1,     16'h0001, 1'b0};
        vecs[2]  = '{14'd9,     16'h0009, 1'b0};
        vecs[3]  = '{14'd10,    16'h0010, 1'b0};
        vecs[4]  = '{14'd99,    16'h0099, 1'b0};
        vecs[5]  = '{14'd100,   16'h0100, 1'b0};
        vecs[6]  = '{14'd1234,  16'h1234, 1'b0};
        vecs[7]  = '{14'd8191,  16'h8191, 1'b0};
        vecs[8]  = '{14'd9999,  16'h9999, 1'b0};
`ifdef BCD_SAT_EN
        vecs[9]  = '{14'd10000, 16'h9999, 1'b1};
        vecs[10] = '{14'd12345, 16'h9999, 1'b1};
        vecs[11] = '{14'd16383, 16'h9999, 1'b1};
`else
        vecs[9]  = '{14'd10000, 16'h0000, 1'b1};
        vecs[10] = '{14'd12345, 16'h2345, 1'b1};
        vecs[11] = '{14'd16383, 16'h6383, 1'b1};
`endif

        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.bin_in = '0;
        #1;
        chk("reset_bcd",  32'(bus.bcd_register), 32'h0000);
        chk("reset_ovf",  32'(bus.ovf),  32'd0);
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_done", 32'(bus.done), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            do_conv(vecs[i].bin, lat, r, o, bok);
            chk($sformatf("vec%0d_bcd", i), 32'(r), 32'(vecs[i].bcd));
            chk($sformatf("vec%0d_ovf", i), 32'(o), 32'(vecs[i].ovf));
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd15);
            chk($sformatf("vec%0d_busy_during", i), 32'(bok), 32'd1);
            chk($sformatf("vec%0d_busy_at_done", i), 32'(bus.busy), 32'd0);
            @(negedge clk);
            chk($sformatf("vec%0d_done_single", i), 32'(bus.done), 32'd0);
            chk($sformatf("vec%0d_hold", i), 32'(bus.bcd_register), 32'(vecs[i].bcd));
        end

        // Back-to-back: second start is driven during the done cycle.
        do_conv(14'd0, lat, r, o, bok);
        chk("b2b_first_bcd", 32'(r), 32'h0000);
        chk("b2b_first_ovf", 32'(o), 32'd0);
        do_conv(14'd9999, lat, r, o, bok);
        chk("b2b_second_bcd", 32'(r), 32'h9999);
        chk("b2b_second_ovf", 32'(o), 32'd0);
        chk("b2b_second_latency", 32'(lat), 32'd15);

        // Restart and bin_in changes during a conversion must be ignored.
        bus.bin_in = 14'd4321;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        ndone = 0;
        first = -1;
        got   = 16'h0000;
        for (int c = 1; c <= 25; c++) begin
            if (c == 5) begin
                bus.bin_in = 14'd5555;
                bus.start  = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            if (c == 8) bus.bin_in = 14'd1111;
            @(negedge clk);
            if (bus.done) begin
                ndone++;
                if (first < 0) begin
                    first = c;
                    got   = bus.bcd_register;
                end
            end
        end
        chk("ignore_done_count", 32'(ndone), 32'd1);
        chk("ignore_latency", 32'(first), 32'd15);
        chk("ignore_bcd", 32'(got), 32'h4321);

        // Asynchronous reset while idle, with a nonzero result on display.
        #2 rst = 1'b1;
        #1;
        chk("idle_rst_bcd",  32'(bus.bcd_register), 32'h0000);
        chk("idle_rst_ovf",  32'(bus.ovf),  32'd0);
        chk("idle_rst_busy", 32'(bus.busy), 32'd0);
        chk("idle_rst_done", 32'(bus.done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset in the middle of a conversion aborts it without a done pulse.
        do_conv(14'd9999, lat, r, o, bok);
        chk("pre_abort_bcd", 32'(r), 32'h9999);
        bus.bin_in = 14'd2500;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_bcd",  32'(bus.bcd_register), 32'h0000);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        chk("abort_no_done", 32'(ndone), 32'd0);
        chk("abort_bcd_held", 32'(bus.bcd_register), 32'h0000);
        do_conv(14'd42, lat, r, o, bok);
        chk("after_abort_bcd", 32'(r), 32'h0042);
        chk("after_abort_ovf", 32'(o), 32'd0);
        chk("after_abort_latency", 32'(lat), 32'd15);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
